fpu_mul_exp_ctl: RTL

FPU_MUL_EXP_CTL -- requirements
Module: fpu_mul_exp_ctl

---
 rtl/fpu_mul_pkg.sv | 19 +
 rtl/fpu_mul_stage_reg.sv | 22 ++
 rtl/fpu_mul_exp_ctl.sv | 111 +++++++++++
 3 files changed

// File: rtl/fpu_mul_pkg.sv
// Shared opcode encodings, clock-hold reload value and the per-stage record
// carried down the FP multiply control pipe.
package fpu_mul_pkg;

   localparam logic [1:0] OP_NONE   = 2'b00;
   localparam logic [1:0] OP_FMULS  = 2'b01;
   localparam logic [1:0] OP_FMULD  = 2'b10;
   localparam logic [1:0] OP_FSMULD = 2'b11;

   localparam logic [1:0] CLK_HOLD_RELOAD = 2'd3;

   typedef struct packed {
      logic       vld;
      logic [1:0] op;
      logic       nan_inf;
      logic       zero;
   } stage_t;

endpackage

// File: rtl/fpu_mul_stage_reg.sv
// One control-pipe stage: valid, opcode and special-operand flags, advanced
// only when the whole pipe steps.
module fpu_mul_stage_reg
   import fpu_mul_pkg::*;
(
   input  logic   rclk,
   input  logic   grst_l,
   input  logic   step,
   input  stage_t d,
   output stage_t q
);

   // NOTE: reset is sampled on the clock edge, so it sits inside the clocked
   // branch rather than in the sensitivity list.
   always_ff @(posedge rclk) begin
      if (!grst_l)
         q <= '0;
      else if (step)
         q <= d;
   end

endmodule

// File: rtl/fpu_mul_exp_ctl.sv
// Six-stage rigid control pipe for the FP multiplier: request handshake,
// per-stage operand qualifiers, m2 exponent select and multiply clock gating.
module fpu_mul_exp_ctl
   import fpu_mul_pkg::*;
(
   input  logic       rclk,
   input  logic       grst_l,
   input  logic       inq_mul_vld,
   input  logic [1:0] inq_op,
   input  logic       inq_nan_inf,
   input  logic       inq_zero,
   output logic       mul_inq_rdy,
   input  logic       out_ack,
   output logic       mul_out_vld,
   output logic       m6stg_step,
   output logic       m1stg_dblop,
   output logic       m1stg_sngop,
   output logic       m1stg_fsmuld,
   output logic       m2stg_exp_expadd,
   output logic       m2stg_exp_0bff,
   output logic       m2stg_exp_017f,
   output logic       m2stg_exp_04ff,
   output logic       m2stg_exp_zero,
   output logic       m2stg_fmuld,
   output logic       m2stg_fmuls,
   output logic       m2stg_fsmuld,
   output logic       m5stg_fmuld,
   output logic       fmul_clken_l
);

   stage_t     stg_d [1:6];
   stage_t     stg_q [1:6];
   stage_t     m1_in;
   logic       accept;
   logic       any_vld;
   logic [1:0] hold_cnt;

   assign m6stg_step  = !stg_q[6].vld | out_ack;
   assign mul_inq_rdy = m6stg_step;
   assign mul_out_vld = stg_q[6].vld;
   assign accept      = inq_mul_vld & mul_inq_rdy & (inq_op != OP_NONE);

   // Only accepted requests enter m1; otherwise a bubble is clocked in.
   assign m1_in = accept ? '{vld: 1'b1, op: inq_op, nan_inf: inq_nan_inf, zero: inq_zero}
                         : '0;

   for (genvar g = 1; g <= 6; g++) begin : g_stage
      if (g == 1) begin : g_head
         assign stg_d[g] = m1_in;
      end else begin : g_body
         assign stg_d[g] = stg_q[g-1];
      end
      fpu_mul_stage_reg u_stage_reg (
         .rclk   (rclk),
         .grst_l (grst_l),
         .step   (m6stg_step),
         .d      (stg_d[g]),
         .q      (stg_q[g])
      );
   end

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      any_vld = 1'b0;
      for (int i = 1; i <= 6; i++)
         any_vld = any_vld | stg_q[i].vld;
   end

   always_ff @(posedge rclk) begin
      if (!grst_l)
         hold_cnt <= '0;
      else if (any_vld || inq_mul_vld)
         hold_cnt <= CLK_HOLD_RELOAD;
      else if (hold_cnt != 2'd0)
         hold_cnt <= hold_cnt - 2'd1;
   end

   assign fmul_clken_l = !(any_vld | inq_mul_vld | (hold_cnt != 2'd0));

   assign m1stg_dblop  = stg_q[1].vld & (stg_q[1].op == OP_FMULD);
   assign m1stg_sngop  = stg_q[1].vld & ((stg_q[1].op == OP_FMULS) | (stg_q[1].op == OP_FSMULD));
   assign m1stg_fsmuld = stg_q[1].vld & (stg_q[1].op == OP_FSMULD);

   assign m2stg_fmuld  = stg_q[2].vld & (stg_q[2].op == OP_FMULD);
   assign m2stg_fmuls  = stg_q[2].vld & (stg_q[2].op == OP_FMULS);
   assign m2stg_fsmuld = stg_q[2].vld & (stg_q[2].op == OP_FSMULD);
   assign m5stg_fmuld  = stg_q[5].vld & (stg_q[5].op == OP_FMULD);

   // NaN/Inf outranks zero; an empty stage selects the zero exponent.
   always_comb begin
      m2stg_exp_expadd = 1'b0;
      m2stg_exp_0bff   = 1'b0;
      m2stg_exp_017f   = 1'b0;
      m2stg_exp_04ff   = 1'b0;
      m2stg_exp_zero   = 1'b0;
      if (!stg_q[2].vld) begin
         m2stg_exp_zero = 1'b1;
      end else if (stg_q[2].nan_inf) begin
         unique case (stg_q[2].op)
            OP_FMULD:  m2stg_exp_0bff = 1'b1;
            OP_FSMULD: m2stg_exp_04ff = 1'b1;
            default:   m2stg_exp_017f = 1'b1;
         endcase
      end else if (stg_q[2].zero) begin
         m2stg_exp_zero = 1'b1;
      end else begin
         m2stg_exp_expadd = 1'b1;
      end
   end

endmodule
